// File: rtl/mem_arbiter_pkg.sv
// Shared types and size encodings for the memory-port arbiter.
// FSM states, owner tags and store-size helpers.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_e;

    typedef enum logic {
        OWNER_IF,
        OWNER_D
    } arb_owner_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    // 2'b10 has no meaning to mem; treat it as a full word.
    function automatic logic [1:0] fix_size(input logic [1:0] s);
        return (s == 2'b10) ? SIZE_WORD : s;
    endfunction

endpackage

// File: rtl/mem_arbiter_sel.sv
// Two-way one-hot grant selector, data over fetch by default.
// MEM_ARBITER_RR_EN: ties go to the requester that lost last time.
module mem_arbiter_sel
    import mem_arbiter_pkg::*;
(
    input  logic       if_req,
    input  logic       d_req,
    input  arb_owner_e last_win,
    output logic       if_gnt,
    output logic       d_gnt
);

    logic pick_if;

`ifdef MEM_ARBITER_RR_EN
    assign pick_if = (last_win == OWNER_D);
`else
    logic sel_unused;
    assign sel_unused = ^last_win;
    assign pick_if    = 1'b0;
`endif

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        unique case (1'b1)
            (if_req && d_req): begin
                if_gnt = pick_if;
                d_gnt  = !pick_if;
            end
            (d_req && !if_req): d_gnt  = 1'b1;
            (if_req && !d_req): if_gnt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/LSU arbiter and sequencer for the single combinational mem port.
// Define MEM_ARBITER_RR_EN for round-robin tie breaking.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int BITSIZE = 32,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               reset_i,
    input  logic               if_req_i,
    input  logic [ADDR_W-1:0]  if_addr_i,
    output logic               if_gnt_o,
    output logic               if_rvalid_o,
    output logic [BITSIZE-1:0] if_rdata_o,
    input  logic               d_req_i,
    input  logic [ADDR_W-1:0]  d_addr_i,
    input  logic               d_we_i,
    input  logic [1:0]         d_size_i,
    input  logic [BITSIZE-1:0] d_wdata_i,
    output logic               d_gnt_o,
    output logic               d_rvalid_o,
    output logic [BITSIZE-1:0] d_rdata_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [BITSIZE-1:0] mem_data_o,
    output logic               mem_write_o,
    output logic [1:0]         mem_write_size_o,
    output logic               mem_valid_o,
    input  logic [BITSIZE-1:0] mem_data_i,
    input  logic               mem_valid_i
);

    arb_state_e state, state_n;
    arb_owner_e owner;
    arb_owner_e last_win;
    logic       sel_if, sel_d;
    logic       arb_ok;

`ifndef MEM_ARBITER_RR_EN
    assign last_win = OWNER_IF;
`endif

    mem_arbiter_sel u_sel (
        .if_req   (if_req_i),
        .d_req    (d_req_i),
        .last_win (last_win),
        .if_gnt   (sel_if),
        .d_gnt    (sel_d)
    );

    always_comb begin
        arb_ok      = !reset_i && (state == IDLE || state == RESP);
        if_gnt_o    = arb_ok && sel_if;
        d_gnt_o     = arb_ok && sel_d;
        if_rvalid_o = (state == RESP) && (owner == OWNER_IF);
        d_rvalid_o  = (state == RESP) && (owner == OWNER_D);
        mem_valid_o = (state == ACCESS);
        state_n     = state;
        unique case (state)
            IDLE, RESP: state_n = (if_gnt_o || d_gnt_o) ? ACCESS : IDLE;
            ACCESS:     if (mem_valid_i) state_n = RESP;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state            <= IDLE;
            owner            <= OWNER_IF;
            mem_addr_o       <= '0;
            mem_data_o       <= '0;
            mem_write_o      <= 1'b0;
            mem_write_size_o <= 2'b00;
            if_rdata_o       <= '0;
            d_rdata_o        <= '0;
`ifdef MEM_ARBITER_RR_EN
            last_win         <= OWNER_IF;
`endif
        end else begin
            state <= state_n;
            if (d_gnt_o) begin
                owner            <= OWNER_D;
                mem_addr_o       <= d_addr_i;
                mem_data_o       <= d_wdata_i;
                mem_write_o      <= d_we_i;
                mem_write_size_o <= fix_size(d_size_i);
            end else if (if_gnt_o) begin
                owner            <= OWNER_IF;
                mem_addr_o       <= if_addr_i;
                mem_write_o      <= 1'b0;
                mem_write_size_o <= SIZE_WORD;
            end
`ifdef MEM_ARBITER_RR_EN
            if (d_gnt_o || if_gnt_o)
                last_win <= d_gnt_o ? OWNER_D : OWNER_IF;
`endif
            if (state == ACCESS && mem_valid_i) begin
                if (owner == OWNER_D) d_rdata_o  <= mem_data_i;
                else                  if_rdata_o <= mem_data_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural combinational mem.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i;
    logic [31:0] d_addr_i;
    logic        d_we_i;
    logic [1:0]  d_size_i;
    logic [31:0] d_wdata_i;
    logic        d_gnt_o, d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic        mem_write_o, mem_valid_o;
    logic [1:0]  mem_write_size_o;
    logic [31:0] mem_data_i;
    logic        mem_valid_i;

    logic [31:0] ram [64];
    logic        stall;
    int          total = 0;
    int          bad   = 0;

`ifdef MEM_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk              (clk),
        .reset_i          (reset_i),
        .if_req_i         (if_req_i),
        .if_addr_i        (if_addr_i),
        .if_gnt_o         (if_gnt_o),
        .if_rvalid_o      (if_rvalid_o),
        .if_rdata_o       (if_rdata_o),
        .d_req_i          (d_req_i),
        .d_addr_i         (d_addr_i),
        .d_we_i           (d_we_i),
        .d_size_i         (d_size_i),
        .d_wdata_i        (d_wdata_i),
        .d_gnt_o          (d_gnt_o),
        .d_rvalid_o       (d_rvalid_o),
        .d_rdata_o        (d_rdata_o),
        .mem_addr_o       (mem_addr_o),
        .mem_data_o       (mem_data_o),
        .mem_write_o      (mem_write_o),
        .mem_write_size_o (mem_write_size_o),
        .mem_valid_o      (mem_valid_o),
        .mem_data_i       (mem_data_i),
        .mem_valid_i      (mem_valid_i)
    );

    assign mem_data_i  = ram[mem_addr_o[7:2]];
    assign mem_valid_i = mem_valid_o && !stall;

    always @(posedge clk) begin
        if (mem_valid_i && mem_write_o) begin
            case (mem_write_size_o)
                2'b00: ram[mem_addr_o[7:2]][8*mem_addr_o[1:0] +: 8] <= mem_data_o[7:0];
                2'b01: ram[mem_addr_o[7:2]][16*mem_addr_o[1] +: 16] <= mem_data_o[15:0];
                default: ram[mem_addr_o[7:2]] <= mem_data_o;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
    endtask

    task automatic d_op(input logic [31:0] addr, input logic we,
                        input logic [1:0] sz, input logic [31:0] wd,
                        input logic [1:0] exp_sz, input logic [31:0] exp_rd);
        @(negedge clk);
        d_req_i = 1'b1; d_addr_i = addr; d_we_i = we;
        d_size_i = sz; d_wdata_i = wd;
        #1;
        chk("d_gnt", d_gnt_o, 1);
        chk("d_gnt_excl", if_gnt_o, 0);
        @(negedge clk);
        d_req_i = 1'b0;
        #1;
        chk("d_acc_valid", mem_valid_o, 1);
        chk("d_acc_addr", mem_addr_o, addr);
        chk("d_acc_we", mem_write_o, we);
        chk("d_acc_size", mem_write_size_o, exp_sz);
        @(negedge clk);
        #1;
        chk("d_rvalid", d_rvalid_o, 1);
        chk("d_rdata", d_rdata_o, exp_rd);
    endtask

    initial begin
        logic exp_d, prev_d;
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        ram[0] = 32'h7c7fe2b7;
        ram[4] = 32'h44332211;
        stall = 1'b0;
        reset_i = 1'b1;
        if_req_i = 1'b0; if_addr_i = '0;
        d_req_i = 1'b0; d_addr_i = '0; d_we_i = 1'b0;
        d_size_i = 2'b00; d_wdata_i = '0;

        do_reset();
        #1;
        chk("rst_if_gnt", if_gnt_o, 0);
        chk("rst_d_rvalid", d_rvalid_o, 0);
        chk("rst_mem_valid", mem_valid_o, 0);
        chk("rst_mem_write", mem_write_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_if_rdata", if_rdata_o, 0);

        // fetch read: grant at N, access at N+1, rvalid at N+2
        @(negedge clk);
        if_req_i = 1'b1; if_addr_i = 32'h0;
        #1;
        chk("f_gnt", if_gnt_o, 1);
        chk("f_mem_valid_idle", mem_valid_o, 0);
        @(negedge clk);
        if_req_i = 1'b0;
        #1;
        chk("f_acc_valid", mem_valid_o, 1);
        chk("f_acc_we", mem_write_o, 0);
        chk("f_no_rvalid", if_rvalid_o, 0);
        @(negedge clk);
        #1;
        chk("f_rvalid", if_rvalid_o, 1);
        chk("f_rdata", if_rdata_o, 32'h7c7fe2b7);
        chk("f_resp_we", mem_write_o, 0);
        @(negedge clk);
        #1;
        chk("f_rvalid_pulse", if_rvalid_o, 0);
        chk("f_rdata_hold", if_rdata_o, 32'h7c7fe2b7);

        // byte store at 0x11, then reload the word
        d_op(32'h11, 1'b1, 2'b00, 32'h000000ab, 2'b00, 32'h44332211);
        d_op(32'h10, 1'b0, 2'b11, 32'h0, 2'b11, 32'h4433ab11);

        // mem holds off for two extra cycles
        @(negedge clk);
        stall = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h10;
        #1;
        chk("s_gnt", if_gnt_o, 1);
        @(negedge clk);
        if_req_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("s_hold_valid", mem_valid_o, 1);
            chk("s_hold_addr", mem_addr_o, 32'h10);
            chk("s_no_rvalid", if_rvalid_o, 0);
            @(negedge clk);
        end
        stall = 1'b0;
        @(negedge clk);
        #1;
        chk("s_rvalid", if_rvalid_o, 1);
        chk("s_rdata", if_rdata_o, 32'h4433ab11);

        // illegal size 10 is issued as a word store
        d_op(32'h20, 1'b1, 2'b10, 32'h11223344, 2'b11, 32'h0);

        // simultaneous requests from a fresh reset
        do_reset();
        d_req_i = 1'b1; d_addr_i = 32'h20; d_we_i = 1'b0; d_size_i = 2'b11;
        if_req_i = 1'b1; if_addr_i = 32'h0;
        #1;
        chk("sim_d_gnt", d_gnt_o, 1);
        chk("sim_if_wait", if_gnt_o, 0);
        @(negedge clk);
        d_req_i = 1'b0;
        #1;
        chk("sim_acc_if_gnt", if_gnt_o, 0);
        chk("sim_acc_addr", mem_addr_o, 32'h20);
        @(negedge clk);
        #1;
        chk("sim_d_rvalid", d_rvalid_o, 1);
        chk("sim_d_rdata", d_rdata_o, 32'h11223344);
        chk("sim_if_gnt_resp", if_gnt_o, 1);
        @(negedge clk);
        if_req_i = 1'b0;
        #1;
        chk("sim_if_acc_addr", mem_addr_o, 32'h0);
        @(negedge clk);
        #1;
        chk("sim_if_rvalid", if_rvalid_o, 1);
        chk("sim_if_rdata", if_rdata_o, 32'h7c7fe2b7);

        // both requests held for 8 grants
        do_reset();
        d_req_i = 1'b1; d_addr_i = 32'h20; d_we_i = 1'b0; d_size_i = 2'b11;
        if_req_i = 1'b1; if_addr_i = 32'h0;
        prev_d = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_d = RR ? ((i % 2) == 0) : 1'b1;
            chk("held_d_gnt", d_gnt_o, exp_d);
            chk("held_if_gnt", if_gnt_o, !exp_d);
            if (i > 0) chk("held_rvalid", d_rvalid_o, prev_d);
            prev_d = exp_d;
            @(negedge clk);
            if (i == 7) begin
                d_req_i = 1'b0; if_req_i = 1'b0;
            end
            @(negedge clk);
        end
        #1;
        chk("held_last_rvalid", d_rvalid_o, prev_d);
        chk("held_last_if_rvalid", if_rvalid_o, !prev_d);

        // reset while the access is on the bus
        @(negedge clk);
        d_req_i = 1'b1; d_addr_i = 32'h10; d_we_i = 1'b0;
        #1;
        chk("ra_gnt", d_gnt_o, 1);
        @(negedge clk);
        d_req_i = 1'b0; reset_i = 1'b1;
        #1;
        chk("ra_acc_valid", mem_valid_o, 1);
        @(negedge clk);
        #1;
        chk("ra_mem_valid", mem_valid_o, 0);
        chk("ra_d_rvalid", d_rvalid_o, 0);
        chk("ra_mem_addr", mem_addr_o, 0);
        chk("ra_d_rdata", d_rdata_o, 0);
        chk("ra_mem_size", mem_write_size_o, 0);
        reset_i = 1'b0;
        @(negedge clk);
        #1;
        chk("ra_no_late_rvalid", d_rvalid_o, 0);
        chk("ra_idle_valid", mem_valid_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
